// File: rtl/eth_rx_addr_filter.sv
// eth_rx_addr_filter: destination-address filter for a received Ethernet byte stream, with frame statistics.
module eth_rx_addr_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_FRAME_LEN = 60,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  input  logic [47:0]            local_mac,
  input  logic                   cfg_promisc,
  input  logic                   cfg_bcast_en,
  input  logic                   cfg_mcast_en,
  output logic                   stat_frame_pass,
  output logic                   stat_frame_drop,
  output logic                   stat_frame_runt,
  output logic                   stat_overrun,
  output logic [COUNT_WIDTH-1:0] pass_count,
  output logic [COUNT_WIDTH-1:0] drop_count
);
  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("eth_rx_addr_filter: DATA_WIDTH must be 8");
  end
  localparam logic [1:0] HDR = 2'd0, PASS = 2'd1, DROP = 2'd2, DRAIN = 2'd3;
  logic [1:0] state;
  logic [5:0][DATA_WIDTH-1:0] sr;
  logic [2:0] hcnt, dcnt;
  logic [15:0] len, len_inc;
  logic tuser_lat, ovr_pend, ovr_next;
  logic [47:0] dst;
  logic bcast, hit, runt, pass_nx, drop_nx;
  // sr[0] holds the newest byte, so byte 0 sits in sr[4] when byte 5 arrives
  assign dst = {sr[4:0], s_axis_tdata};
  assign bcast = &dst;
  assign hit = cfg_promisc | (dst == local_mac) | (bcast & cfg_bcast_en) | (sr[4][0] & ~bcast & cfg_mcast_en);
  assign runt = len < 16'(MIN_FRAME_LEN);
  assign len_inc = &len ? len : len + 16'd1;
  assign ovr_next = s_axis_tvalid ? ~s_axis_tlast : ovr_pend;
  assign pass_nx = state == DRAIN && dcnt == 3'd5;
  assign drop_nx = s_axis_tvalid & s_axis_tlast & (
                   (state == HDR && (hcnt != 3'd5 || !hit)) ||
                   state == DROP ||
                   (state == DRAIN && ovr_pend));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR;
      sr <= '0;
      hcnt <= '0;
      dcnt <= '0;
      len <= '0;
      tuser_lat <= 1'b0;
      ovr_pend <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= 1'b0;
      stat_frame_pass <= 1'b0;
      stat_frame_drop <= 1'b0;
      stat_frame_runt <= 1'b0;
      stat_overrun <= 1'b0;
      pass_count <= '0;
      drop_count <= '0;
    end else begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast <= 1'b0;
      m_axis_tuser <= 1'b0;
      stat_frame_runt <= 1'b0;
      stat_overrun <= 1'b0;
      stat_frame_pass <= pass_nx;
      stat_frame_drop <= drop_nx;
      pass_count <= pass_count + COUNT_WIDTH'(pass_nx);
      drop_count <= drop_count + COUNT_WIDTH'(drop_nx);
      case (state)
        HDR: if (s_axis_tvalid) begin
          sr <= {sr[4:0], s_axis_tdata};
          len <= len_inc;
          hcnt <= hcnt + 3'd1;
          if (hcnt != 3'd5 && s_axis_tlast) begin
            hcnt <= '0;
            len <= '0;
            stat_frame_runt <= 1'b1;
          end else if (hcnt == 3'd5) begin
            hcnt <= '0;
            tuser_lat <= s_axis_tuser;
            dcnt <= '0;
            state <= hit ? (s_axis_tlast ? DRAIN : PASS) : (s_axis_tlast ? HDR : DROP);
            if (!hit && s_axis_tlast) len <= '0;
          end
        end
        PASS: if (s_axis_tvalid) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata <= sr[5];
          sr <= {sr[4:0], s_axis_tdata};
          len <= len_inc;
          if (s_axis_tlast) begin
            state <= DRAIN;
            tuser_lat <= s_axis_tuser;
          end
        end
        DROP: if (s_axis_tvalid && s_axis_tlast) begin
          state <= HDR;
          len <= '0;
        end
        default: begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata <= sr[5];
          sr <= {sr[4:0], DATA_WIDTH'(0)};
          dcnt <= dcnt + 3'd1;
          stat_overrun <= s_axis_tvalid;
          ovr_pend <= ovr_next;
          if (dcnt == 3'd5) begin
            m_axis_tlast <= 1'b1;
            m_axis_tuser <= tuser_lat | runt;
            stat_frame_runt <= runt;
            dcnt <= '0;
            ovr_pend <= 1'b0;
            len <= '0;
            state <= ovr_next ? DROP : HDR;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// tb_eth_rx_addr_filter: directed scenario tests for eth_rx_addr_filter.
module tb_eth_rx_addr_filter;
  logic clk = 0, rst = 1;
  logic [7:0] s_axis_tdata = 0;
  logic s_axis_tvalid = 0, s_axis_tlast = 0, s_axis_tuser = 0;
  logic [7:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic [47:0] local_mac = 48'h02_00_00_00_00_01;
  logic cfg_promisc = 0, cfg_bcast_en = 0, cfg_mcast_en = 0;
  logic stat_frame_pass, stat_frame_drop, stat_frame_runt, stat_overrun;
  logic [31:0] pass_count, drop_count;
  int checks = 0, errors = 0;
  int n_last, n_pass, n_drop, n_runt, n_ovr, n_mid_tuser, cyc, first_cyc, last_cyc;
  logic last_tuser;
  logic [7:0] out_q[$];
  logic [31:0] exp_pass = 0, exp_drop = 0;
  localparam logic [47:0] MAC_ME = 48'h02_00_00_00_00_01, MAC_OTHER = 48'h02_00_00_00_00_02;
  localparam logic [47:0] MAC_BC = 48'hFF_FF_FF_FF_FF_FF, MAC_MC = 48'h01_00_5E_00_00_01;

  eth_rx_addr_filter dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .local_mac(local_mac), .cfg_promisc(cfg_promisc), .cfg_bcast_en(cfg_bcast_en), .cfg_mcast_en(cfg_mcast_en),
    .stat_frame_pass(stat_frame_pass), .stat_frame_drop(stat_frame_drop), .stat_frame_runt(stat_frame_runt),
    .stat_overrun(stat_overrun), .pass_count(pass_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_axis_tvalid) begin
      if (out_q.size() == 0) first_cyc = cyc;
      last_cyc = cyc;
      out_q.push_back(m_axis_tdata);
      if (m_axis_tlast) begin
        n_last++;
        last_tuser = m_axis_tuser;
      end else if (m_axis_tuser) n_mid_tuser++;
    end
    n_pass += int'(stat_frame_pass);
    n_drop += int'(stat_frame_drop);
    n_runt += int'(stat_frame_runt);
    n_ovr += int'(stat_overrun);
  end

  function automatic logic [7:0] fbyte(input logic [47:0] d, input int i);
    logic [47:0] t;
    t = d << (8 * i);
    return i < 6 ? t[47:40] : 8'(i * 3 + 1);
  endfunction

  task automatic clr();
    @(negedge clk);
    out_q.delete();
    n_last = 0; n_pass = 0; n_drop = 0; n_runt = 0; n_ovr = 0; n_mid_tuser = 0;
    last_tuser = 0; first_cyc = 0; last_cyc = 0;
  endtask

  task automatic send(input logic [47:0] d, input int n, input bit tu);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1;
      s_axis_tdata = fbyte(d, i);
      s_axis_tlast = i == n - 1;
      s_axis_tuser = tu && i == n - 1;
    end
    @(negedge clk);
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tuser = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_frame(input string name, input logic [47:0] d, input int n, input bit tu);
    int bad = 0;
    checks++;
    if (out_q.size() != n) begin errors++; $display("FAIL %s bytes got %0d want %0d", name, out_q.size(), n); end
    for (int i = 0; i < out_q.size() && i < n; i++) if (out_q[i] !== fbyte(d, i)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s data got %0d wrong bytes want 0", name, bad); end
    checks++;
    if (n_last != 1 || last_tuser !== tu) begin errors++; $display("FAIL %s tlast/tuser got %0d/%b want 1/%b", name, n_last, last_tuser, tu); end
    checks++;
    if (last_cyc - first_cyc != n - 1 || n_mid_tuser != 0) begin errors++; $display("FAIL %s contiguity span %0d mid_tuser %0d want %0d/0", name, last_cyc - first_cyc, n_mid_tuser, n - 1); end
  endtask

  task automatic chk_counts(input string name);
    checks++;
    if (pass_count !== exp_pass || drop_count !== exp_drop) begin
      errors++; $display("FAIL %s counts got pass %0d drop %0d want %0d %0d", name, pass_count, drop_count, exp_pass, exp_drop);
    end
  endtask

  task automatic test_reset();
    rst = 1; idle(3);
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 11'd0) begin errors++; $display("FAIL reset m_axis got %b %b %b %h want 0", m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata); end
    checks++;
    if ({stat_frame_pass, stat_frame_drop, stat_frame_runt, stat_overrun} !== 4'd0) begin errors++; $display("FAIL reset stats got %b want 0000", {stat_frame_pass, stat_frame_drop, stat_frame_runt, stat_overrun}); end
    checks++;
    if (pass_count !== 0 || drop_count !== 0) begin errors++; $display("FAIL reset counters got %0d %0d want 0 0", pass_count, drop_count); end
    rst = 0; exp_pass = 0; exp_drop = 0;
  endtask

  task automatic test_unicast();
    clr(); send(MAC_ME, 64, 0); idle(10);
    exp_pass++;
    chk_frame("unicast64", MAC_ME, 64, 0);
    checks++;
    if (n_pass != 1 || n_runt != 0 || n_drop != 0) begin errors++; $display("FAIL unicast pulses got p%0d r%0d d%0d want 1 0 0", n_pass, n_runt, n_drop); end
    chk_counts("unicast");
    clr(); send(MAC_ME, 60, 0); idle(10);
    exp_pass++;
    chk_frame("unicast60", MAC_ME, 60, 0);
    checks++;
    if (n_runt != 0) begin errors++; $display("FAIL len60 runt got %0d want 0", n_runt); end
    clr(); send(MAC_ME, 59, 0); idle(10);
    exp_pass++;
    chk_frame("unicast59", MAC_ME, 59, 1);
    chk_counts("boundary");
  endtask

  task automatic test_filter();
    clr(); send(MAC_OTHER, 64, 0); idle(10);
    exp_drop++;
    checks++;
    if (out_q.size() != 0 || n_drop != 1) begin errors++; $display("FAIL other out %0d drops %0d want 0 1", out_q.size(), n_drop); end
    chk_counts("other");
    cfg_promisc = 1;
    clr(); send(MAC_OTHER, 64, 0); idle(10);
    cfg_promisc = 0; exp_pass++;
    chk_frame("promisc", MAC_OTHER, 64, 0);
    clr(); send(MAC_BC, 64, 0); idle(10);
    exp_drop++;
    checks++;
    if (out_q.size() != 0) begin errors++; $display("FAIL bcast_off out %0d want 0", out_q.size()); end
    cfg_bcast_en = 1;
    clr(); send(MAC_BC, 64, 0); idle(10);
    cfg_bcast_en = 0; exp_pass++;
    chk_frame("bcast_on", MAC_BC, 64, 0);
    clr(); send(MAC_MC, 64, 0); idle(10);
    exp_drop++;
    checks++;
    if (out_q.size() != 0) begin errors++; $display("FAIL mcast_off out %0d want 0", out_q.size()); end
    cfg_mcast_en = 1;
    clr(); send(MAC_MC, 64, 0); idle(10);
    exp_pass++;
    chk_frame("mcast_on", MAC_MC, 64, 0);
    clr(); send(MAC_BC, 64, 0); idle(10);
    cfg_mcast_en = 0; exp_drop++;
    checks++;
    if (out_q.size() != 0) begin errors++; $display("FAIL bcast_via_mcast out %0d want 0", out_q.size()); end
    chk_counts("filter");
  endtask

  task automatic test_runt();
    clr(); send(MAC_ME, 40, 0); idle(10);
    exp_pass++;
    chk_frame("runt40", MAC_ME, 40, 1);
    checks++;
    if (n_runt != 1 || n_pass != 1) begin errors++; $display("FAIL runt40 pulses r%0d p%0d want 1 1", n_runt, n_pass); end
    clr(); send(MAC_ME, 6, 0); idle(10);
    exp_pass++;
    chk_frame("runt6", MAC_ME, 6, 1);
    clr(); send(MAC_ME, 4, 0); idle(10);
    exp_drop++;
    checks++;
    if (out_q.size() != 0 || n_drop != 1 || n_runt != 1) begin errors++; $display("FAIL runt4 out %0d d%0d r%0d want 0 1 1", out_q.size(), n_drop, n_runt); end
    chk_counts("runt");
  endtask

  task automatic test_tuser();
    clr(); send(MAC_ME, 64, 1); idle(10);
    exp_pass++;
    chk_frame("tuser", MAC_ME, 64, 1);
    chk_counts("tuser");
  endtask

  task automatic test_back_to_back();
    clr(); send(MAC_ME, 64, 0); send(MAC_ME, 64, 0); idle(10);
    exp_pass++; exp_drop++;
    chk_frame("b2b", MAC_ME, 64, 0);
    checks++;
    if (n_ovr != 5 || n_drop != 1 || n_pass != 1) begin errors++; $display("FAIL b2b ovr %0d drop %0d pass %0d want 5 1 1", n_ovr, n_drop, n_pass); end
    chk_counts("b2b");
  endtask

  task automatic test_reset_mid();
    clr();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_axis_tvalid = 1; s_axis_tdata = fbyte(MAC_ME, i); s_axis_tlast = 0;
    end
    @(negedge clk);
    s_axis_tvalid = 0; rst = 1;
    idle(2); rst = 0;
    clr(); idle(10);
    exp_pass = 0; exp_drop = 0;
    checks++;
    if (out_q.size() != 0 || n_pass != 0 || n_drop != 0) begin errors++; $display("FAIL rst_mid out %0d p%0d d%0d want 0 0 0", out_q.size(), n_pass, n_drop); end
    chk_counts("rst_mid");
    clr(); send(MAC_ME, 64, 0); idle(10);
    exp_pass++;
    chk_frame("after_rst", MAC_ME, 64, 0);
    chk_counts("after_rst");
  endtask

  initial begin
    cyc = 0;
    test_reset();
    test_unicast();
    test_filter();
    test_runt();
    test_tuser();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
